// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream packer and its inserter.
package bitstream_pkg;

  localparam int BP_OUT_W    = 32;
  localparam int BP_MAX_CODE = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TAIL  = 2'd2,
    DONE  = 2'd3
  } bp_state_t;

  // Valid bytes in a partial tail word: ceil(bits/8) for 1..31 bits.
  function automatic logic [2:0] tail_bytes(input logic [4:0] bits);
    logic [5:0] rounded;
    rounded = {1'b0, bits} + 6'd7;
    return rounded[5:3];
  endfunction

endpackage

// File: rtl/bit_inserter.sv
// Masks a right-justified codeword to len bits and ORs it into acc just below
// the fill bits already present (MSB-first stream order).
module bit_inserter
  import bitstream_pkg::*;
#(
  parameter int BUF_W  = 128,
  parameter int FILL_W = 8,
  parameter int LEN_W  = 7
) (
  input  logic [BUF_W-1:0]       acc_in,
  input  logic [FILL_W-1:0]      fill,
  input  logic [BP_MAX_CODE-1:0] val,
  input  logic [LEN_W-1:0]       len,
  output logic [BUF_W-1:0]       acc_out
);

  logic [BP_MAX_CODE-1:0] mask;
  logic [BP_MAX_CODE-1:0] masked;
  logic [BUF_W-1:0]       aligned;

  always_comb begin
    mask    = (len >= LEN_W'(BP_MAX_CODE)) ? '1
                                           : ((BP_MAX_CODE'(1) << len) - BP_MAX_CODE'(1));
    masked  = val & mask;
    // Left-align the code at the top of the buffer, then slide it down past fill.
    aligned = {masked, {(BUF_W - BP_MAX_CODE){1'b0}}} << (LEN_W'(BP_MAX_CODE) - len);
    acc_out = acc_in | (aligned >> fill);
  end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length codewords MSB-first into 32-bit big-endian words,
// pads the slice to a byte boundary on flush and reports the slice byte total.
module bitstream_packer
  import bitstream_pkg::*;
#(
  parameter int BUF_W    = 128,
  parameter int MAX_CODE = BP_MAX_CODE,
  parameter int OUT_W    = BP_OUT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sb_enable,
  input  logic [BP_MAX_CODE-1:0] sb_val,
  input  logic [63:0]            sb_size_of_bit,
  input  logic                   sb_flush,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [2:0]             out_bytes,
  output logic                   out_last,
  output logic [31:0]            byte_count,
  output logic                   done,
  output logic                   size_err
);

  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int LEN_W  = $clog2(BP_MAX_CODE + 1);

  bp_state_t         state, state_n;
  logic [BUF_W-1:0]  acc, acc_pop, acc_ins;
  logic [FILL_W-1:0] fill, fill_pop, fill_n;
  logic [LEN_W-1:0]  code_len;
  logic              pop, take, bad_size, word_valid_n;

  // NOTE: every always_comb output is given a default first, so no latch can be inferred.
  always_comb begin
    pop      = out_valid && out_ready;
    take     = sb_enable && in_ready;
    bad_size = take && (sb_size_of_bit > 64'(MAX_CODE));
    code_len = (take && !bad_size) ? sb_size_of_bit[LEN_W-1:0] : '0;
    acc_pop  = acc;
    fill_pop = fill;
    if (pop) begin
      // The tail word carries every remaining bit, so its pop empties the buffer.
      if (state == TAIL) begin
        acc_pop  = '0;
        fill_pop = '0;
      end else begin
        acc_pop  = acc << OUT_W;
        fill_pop = fill - FILL_W'(OUT_W);
      end
    end
  end

  bit_inserter #(
    .BUF_W (BUF_W),
    .FILL_W(FILL_W),
    .LEN_W (LEN_W)
  ) u_inserter (
    .acc_in (acc_pop),
    .fill   (fill_pop),
    .val    (sb_val),
    .len    (code_len),
    .acc_out(acc_ins)
  );

  always_comb begin
    fill_n  = fill_pop + FILL_W'(code_len);
    state_n = state;
    case (state)
      RUN:   if (sb_flush && in_ready) state_n = DRAIN;
      DRAIN: if (fill_pop < FILL_W'(OUT_W)) state_n = (fill_pop == '0) ? DONE : TAIL;
      TAIL:  if (pop) state_n = DONE;
      DONE:  state_n = RUN;
      default: state_n = RUN;
    endcase
    word_valid_n = (state_n == TAIL) ||
                   ((state_n == RUN || state_n == DRAIN) && fill_n >= FILL_W'(OUT_W));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      acc        <= '0;
      fill       <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bytes  <= '0;
      out_last   <= 1'b0;
      byte_count <= '0;
      done       <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_ins;
      fill      <= fill_n;
      in_ready  <= (state_n == RUN) && (fill_n <= FILL_W'(BUF_W - MAX_CODE));
      out_valid <= word_valid_n;
      out_data  <= acc_ins[BUF_W-1 -: OUT_W];
      if (!word_valid_n)     out_bytes <= '0;
      else if (state_n == TAIL) out_bytes <= tail_bytes(fill_n[4:0]);
      else                   out_bytes <= 3'd4;
      // A full word ends the slice only when draining leaves nothing behind it.
      out_last  <= (state_n == TAIL) || (state_n == DRAIN && fill_n == FILL_W'(OUT_W));
      if (state == DONE)     byte_count <= '0;
      else if (pop)          byte_count <= byte_count + 32'(out_bytes);
      done      <= (state_n == DONE);
      size_err  <= size_err | bad_size;
    end
  end

endmodule
